uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BIT, default 8, number of data bits per frame (legal 5..8).
REQ-002 SHALL have parameter STOP_BIT, default 1, number of stop bits per frame (legal 1..2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_tick  input  1  oversample strobe, 16 per bit period, one clk wide.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle HIGH.
REQ-007 SHALL have port rx_done_tick  output  1  one-clk pulse: frame complete.
REQ-008 SHALL have port rx_data  output  8  last received data, LSB-first reassembled, right-justified.
REQ-009 SHALL have port frame_err  output  1  one-clk pulse coincident with rx_done_tick; present only under UART_RX_FRAME_ERR_EN.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; all FSM decisions use the synchronized value (rx_s).
REQ-011 SHALL implement FSM states idle, start, data, stop; counters s (0..31, s_ticks) and n (0..7, bits).
REQ-012 idle: on rx_s==0 SHALL go to start with s=0; s_tick ignored in idle.
REQ-013 start: on s_tick with s==7, SHALL go to data (s=0, n=0) if rx_s==0, else return to idle (glitch reject, no pulse); other s_ticks increment s.
REQ-014 data: on s_tick with s==15, SHALL shift rx_s into bit 7 of shift register (right shift), s=0; if n==DATA_BIT-1 go to stop, else n+1.
REQ-015 stop: on s_tick with s==STOP_BIT*16-1, SHALL go to idle and schedule completion; other s_ticks increment s.
REQ-016 Completion: on the clk after the final stop s_tick, rx_done_tick SHALL be 1 for exactly one clk and rx_data SHALL load shift register >> (8-DATA_BIT), unused upper bits 0.
REQ-017 rx_data SHALL hold its value between completions; no other update path.
REQ-018 Sampling SHALL be at bit mid-point (8 s_ticks after detected falling edge, then every 16).
REQ-019 A new falling edge immediately after returning to idle SHALL be accepted (back-to-back frames, no idle gap required).
REQ-020 Latency: rx_done_tick SHALL assert 2 clk (sync) + FSM time after last stop sample; no s_tick counted when s_tick and state change coincide except as defined above.
REQ-021 rx held LOW indefinitely SHALL produce repeated frames of 0x00 (with frame_err under macro), never lockup.

Reset
REQ-022 On reset: state=idle, s=0, n=0, shift register=0, rx_data=0x00, rx_done_tick=0, frame_err=0, synchronizer flops=1.
REQ-023 Reset mid-frame SHALL abort without rx_done_tick; first valid frame after release SHALL be received correctly.

Configuration
REQ-024 Macro UART_RX_FRAME_ERR_EN defined: rx_s sampled at each stop-bit mid-point; any LOW sample SHALL set frame_err pulse with rx_done_tick; rx_data still loaded.
REQ-025 Macro undefined: no frame_err port, no stop-bit check, stop bits only timed.

Structure
REQ-026 Package uart_pkg SHALL hold the rx state enum typedef and constant OVERSAMPLE=16.
REQ-027 Sub-module uart_rx_sync (2-flop synchronizer, reset value 1) SHALL be instantiated once.

Verification (s_tick every 4 clk unless noted)
REQ-028 Frame 0x55, 8N1 -> one rx_done_tick, rx_data=0x55, frame_err=0.
REQ-029 0xA5 then 0x3C back-to-back, no idle gap -> two pulses, rx_data 0xA5 then 0x3C.
REQ-030 rx LOW for 4 s_ticks then HIGH -> no rx_done_tick, FSM returns idle, rx_data unchanged.
REQ-031 0xFF with stop bit driven LOW (macro defined) -> rx_done_tick, rx_data=0xFF, frame_err=1.
REQ-032 reset pulsed during data bit 3 -> all outputs 0, no pulse; following frame 0x81 -> rx_data=0x81.
REQ-033 DATA_BIT=7, STOP_BIT=2, frame 0x41 -> rx_data=0x41, single pulse after second stop bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, oversample ratio
// and the helper that right-justifies the assembled shift register.
package uart_pkg;

  // s_ticks per bit period; start-bit mid-point is half of that
  localparam int OVERSAMPLE = 16;
  localparam int HALF_BIT   = OVERSAMPLE / 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  // Bits enter at the MSB and shift right, so a short frame sits in the
  // upper bits; move it down and leave the unused MSBs zero.
  function automatic logic [7:0] rx_align(input logic [7:0] sr, input int nbits);
    return sr >> (8 - nbits);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops
// reset to 1 so the line reads as idle while and right after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // two back-to-back flops, idle-high reset value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first. Samples each data bit at its
// mid-point (8 s_ticks after the start edge, then every 16). Optional
// stop-bit checking is enabled with the macro UART_RX_FRAME_ERR_EN, which
// also adds the frame_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BIT = 8,
  parameter int STOP_BIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic       rx_done_tick,
  output logic [7:0] rx_data
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  // terminal counts for each phase of the frame
  localparam logic [4:0] S_START_LAST = 5'(HALF_BIT - 1);
  localparam logic [4:0] S_BIT_LAST   = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] S_STOP_LAST  = 5'(STOP_BIT * OVERSAMPLE - 1);
  localparam logic [2:0] N_LAST       = 3'(DATA_BIT - 1);

  logic       rx_s;
  rx_state_t  state_q, state_d;
  logic [4:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [7:0] b_q, b_d;
  logic       done_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic       err_q, err_d;
`endif

  uart_rx_sync u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  // FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
`ifdef UART_RX_FRAME_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
`ifdef UART_RX_FRAME_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // next-state: hunt for start edge, confirm at mid-start, sample data, time stop
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // s_tick is irrelevant here; the edge itself starts the count
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_START_LAST) begin
            s_d = '0;
            if (!rx_s) begin
              state_d = ST_DATA;
              n_d     = '0;
            end else begin
              // line went back high before mid-start: treat as a glitch
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            b_d = {rx_s, b_q[7:1]};
            s_d = '0;
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
`ifdef UART_RX_FRAME_ERR_EN
              err_d   = 1'b0;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
`ifdef UART_RX_FRAME_ERR_EN
          // every stop-bit mid-point lands on s = 15 or 31
          if ((s_q[3:0] == S_BIT_LAST[3:0]) && !rx_s)
            err_d = 1'b1;
`endif
          if (s_q == S_STOP_LAST) begin
            // finish at the last stop mid-point so a back-to-back start
            // edge half a bit later is still caught
            state_d = ST_IDLE;
            s_d     = '0;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // completion: one-clk pulse and data load on the clk after the final stop tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_done_tick <= 1'b0;
      rx_data      <= '0;
    end else begin
      rx_done_tick <= done_d;
      if (done_d)
        rx_data <= rx_align(b_q, DATA_BIT);
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  // frame error pulse, aligned with rx_done_tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frame_err <= 1'b0;
    else
      frame_err <= done_d & err_d;
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: 8N1 instance plus a 7-data/2-stop instance. Expected
// frames are queued when sent and popped by a pulse monitor.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx2 = 1'b1;
  logic       done1, done2;
  logic [7:0] data1, data2;
`ifdef UART_RX_FRAME_ERR_EN
  logic       ferr1, ferr2;
`endif

  int   n_pass = 0;
  int   n_total = 0;
  int   pulses1 = 0;
  int   pulses2 = 0;
  int   tdiv = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  uart_rx dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .rx_done_tick(done1),
    .rx_data     (data1)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err   (ferr1)
`endif
  );

  uart_rx #(.DATA_BIT(7), .STOP_BIT(2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx2),
    .rx_done_tick(done2),
    .rx_data     (data2)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err   (ferr2)
`endif
  );

  always #5 clk = ~clk;

  // one-clk s_tick every 4 clk
  always @(negedge clk) begin
    tdiv   = (tdiv + 1) % 4;
    s_tick = (tdiv == 0);
  end

  // scoreboard monitors: pop on every completion pulse
  always @(negedge clk) begin
    if (done1) begin
      pulses1++;
      n_total++;
      if (q1.size() == 0) begin
        $display("FAIL dut1_unexpected_pulse: rx_data=%h, no frame expected", data1);
      end else begin
        e1 = q1.pop_front();
        if (data1 !== e1.data)
          $display("FAIL dut1_rx_data: got %h expected %h", data1, e1.data);
        else
          n_pass++;
`ifdef UART_RX_FRAME_ERR_EN
        n_total++;
        if (ferr1 !== e1.ferr)
          $display("FAIL dut1_frame_err: got %b expected %b", ferr1, e1.ferr);
        else
          n_pass++;
`endif
      end
    end
    if (done2) begin
      pulses2++;
      n_total++;
      if (q2.size() == 0) begin
        $display("FAIL dut2_unexpected_pulse: rx_data=%h, no frame expected", data2);
      end else begin
        e2 = q2.pop_front();
        if (data2 !== e2.data)
          $display("FAIL dut2_rx_data: got %h expected %h", data2, e2.data);
        else
          n_pass++;
`ifdef UART_RX_FRAME_ERR_EN
        n_total++;
        if (ferr2 !== e2.ferr)
          $display("FAIL dut2_frame_err: got %b expected %b", ferr2, e2.ferr);
        else
          n_pass++;
`endif
      end
    end
  end

  // hold one line at a level for a number of s_tick periods
  task automatic drive(input bit which, input logic v, input int ticks);
    if (which) rx2 = v;
    else       rx  = v;
    repeat (ticks * 4) @(negedge clk);
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input int nbits, input int nstop);
    drive(which, 1'b0, 16);
    for (int i = 0; i < nbits; i++) drive(which, d[i], 16);
    for (int i = 0; i < nstop; i++) drive(which, 1'b1, 16);
  endtask

  task automatic test_reset;
    repeat (6) @(negedge clk);
    n_total++;
    if (data1 !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", data1);
    else n_pass++;
    n_total++;
    if (done1 !== 1'b0) $display("FAIL reset_done: got %b expected 0", done1);
    else n_pass++;
    n_total++;
    if (data2 !== 8'h00) $display("FAIL reset_rx_data2: got %h expected 00", data2);
    else n_pass++;
`ifdef UART_RX_FRAME_ERR_EN
    n_total++;
    if (ferr1 !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", ferr1);
    else n_pass++;
`endif
    reset = 1'b0;
    drive(0, 1'b1, 8);
  endtask

  task automatic test_single;
    int p0;
    p0 = pulses1;
    q1.push_back('{data: 8'h55, ferr: 1'b0});
    send_frame(0, 8'h55, 8, 1);
    drive(0, 1'b1, 16);
    n_total++;
    if (pulses1 - p0 !== 1) $display("FAIL single_pulse_count: got %0d expected 1", pulses1 - p0);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = pulses1;
    q1.push_back('{data: 8'hA5, ferr: 1'b0});
    q1.push_back('{data: 8'h3C, ferr: 1'b0});
    send_frame(0, 8'hA5, 8, 1);
    send_frame(0, 8'h3C, 8, 1);
    drive(0, 1'b1, 16);
    n_total++;
    if (pulses1 - p0 !== 2) $display("FAIL b2b_pulse_count: got %0d expected 2", pulses1 - p0);
    else n_pass++;
    n_total++;
    if (data1 !== 8'h3C) $display("FAIL b2b_last_data: got %h expected 3c", data1);
    else n_pass++;
  endtask

  task automatic test_glitch;
    int p0;
    p0 = pulses1;
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 32);
    n_total++;
    if (pulses1 - p0 !== 0) $display("FAIL glitch_pulse_count: got %0d expected 0", pulses1 - p0);
    else n_pass++;
    n_total++;
    if (data1 !== 8'h3C) $display("FAIL glitch_rx_data: got %h expected 3c", data1);
    else n_pass++;
    n_total++;
    if (dut.state_q !== ST_IDLE) $display("FAIL glitch_state: got %0d expected idle", dut.state_q);
    else n_pass++;
  endtask

  // stop bit low through its mid-point, then released before a false start confirms
  task automatic test_bad_stop;
    int p0;
    p0 = pulses1;
`ifdef UART_RX_FRAME_ERR_EN
    q1.push_back('{data: 8'hFF, ferr: 1'b1});
`else
    q1.push_back('{data: 8'hFF, ferr: 1'b0});
`endif
    drive(0, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(0, 1'b1, 16);
    drive(0, 1'b0, 10);
    drive(0, 1'b1, 38);
    n_total++;
    if (pulses1 - p0 !== 1) $display("FAIL bad_stop_pulse_count: got %0d expected 1", pulses1 - p0);
    else n_pass++;
  endtask

  task automatic test_reset_midframe;
    int p0;
    logic [7:0] d;
    p0 = pulses1;
    d = 8'h5A;
    drive(0, 1'b0, 16);
    for (int i = 0; i < 3; i++) drive(0, d[i], 16);
    drive(0, d[3], 8);
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (data1 !== 8'h00) $display("FAIL midreset_rx_data: got %h expected 00", data1);
    else n_pass++;
    n_total++;
    if (done1 !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done1);
    else n_pass++;
    reset = 1'b0;
    drive(0, 1'b1, 16);
    n_total++;
    if (pulses1 - p0 !== 0) $display("FAIL midreset_pulse_count: got %0d expected 0", pulses1 - p0);
    else n_pass++;
    q1.push_back('{data: 8'h81, ferr: 1'b0});
    send_frame(0, 8'h81, 8, 1);
    drive(0, 1'b1, 16);
    n_total++;
    if (pulses1 - p0 !== 1) $display("FAIL after_reset_pulse_count: got %0d expected 1", pulses1 - p0);
    else n_pass++;
  endtask

  task automatic test_7bit_2stop;
    int p0;
    logic [7:0] d;
    p0 = pulses2;
    d = 8'h41;
    q2.push_back('{data: 8'h41, ferr: 1'b0});
    drive(1, 1'b0, 16);
    for (int i = 0; i < 7; i++) drive(1, d[i], 16);
    drive(1, 1'b1, 16);
    n_total++;
    if (pulses2 - p0 !== 0) $display("FAIL dut2_early_pulse: got %0d expected 0", pulses2 - p0);
    else n_pass++;
    drive(1, 1'b1, 16);
    drive(1, 1'b1, 16);
    n_total++;
    if (pulses2 - p0 !== 1) $display("FAIL dut2_pulse_count: got %0d expected 1", pulses2 - p0);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_bad_stop;
    test_reset_midframe;
    test_7bit_2stop;
    n_total++;
    if (q1.size() + q2.size() !== 0)
      $display("FAIL scoreboard_drain: got %0d frames outstanding expected 0", q1.size() + q2.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
